// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared AES types, S-box, xtime and key-schedule sizing helpers.
//  Revision : 1.0
// ============================================================================
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Entry 0x00 sits in the top byte of the vector.
    localparam logic [2047:0] c_sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [10:0] base;
        base = {~a, 3'b000};
        return c_sbox_table[base +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nwords(input int nr);
        return 4 * (nr + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_subword.sv
`default_nettype none
// ============================================================================
//  Module   : aes_subword
//  Purpose  : Combinational SubWord: four parallel S-box lookups on one word.
//  Revision : 1.0
// ============================================================================
module aes_subword
    import aes_pkg::*;
(
    input  word_t i_word,
    output word_t o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign o_word[8*g +: 8] = sbox(i_word[8*g +: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : key_schedule_ctrl
//  Purpose  : Sequential AES key expansion (one word per cycle) and
//             request/response round-key server.
//  Revision : 1.0
// ============================================================================
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NK*32-1:0] key,
    output logic            busy,
    output logic            key_valid,
    input  logic            rk_req,
    input  logic [3:0]      rk_round,
    output logic            rk_valid,
    output logic            rk_err,
    output logic [127:0]    rk_data
);

    localparam int         c_nwords = nwords(NR);
    localparam logic [5:0] c_last   = 6'(c_nwords - 1);
    localparam logic [5:0] c_nk     = 6'(NK);
    localparam logic [2:0] c_p_last = 3'(NK - 1);
    localparam logic [3:0] c_nr     = 4'(NR);

    state_t       state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   phase_q, phase_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         busy_q, busy_d;
    logic         key_valid_q, key_valid_d;
    logic         rk_valid_q, rk_valid_d;
    logic         rk_err_q, rk_err_d;
    logic [127:0] rk_data_q, rk_data_d;
    word_t        store_q [c_nwords];
    word_t        store_d [c_nwords];

    word_t w_prev, w_back, w_sub_in, w_sub_out, w_temp;
    logic  w_rd_ok;

    assign w_prev   = store_q[idx_q - 6'd1];
    assign w_back   = store_q[idx_q - c_nk];
    assign w_sub_in = (phase_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_subword u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (phase_q == 3'd0) begin
            w_temp = w_sub_out ^ {rcon_q, 24'h0};
        end else if (NK > 6 && phase_q == 3'd4) begin
            w_temp = w_sub_out;
        end
    end

    // start wins from any state: the key is captured on the sampling edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        rcon_d  = rcon_q;
        store_d = store_q;
        if (start) begin
            state_d = ST_LOAD;
            for (int k = 0; k < NK; k++) begin
                store_d[6'(k)] = key[NK*32-1-32*k -: 32];
            end
            idx_d   = c_nk;
            phase_d = 3'd0;
            rcon_d  = 8'h01;
        end else begin
            case (state_q)
                ST_LOAD: state_d = ST_EXPAND;
                ST_EXPAND: begin
                    store_d[idx_q] = w_back ^ w_temp;
                    idx_d   = idx_q + 6'd1;
                    phase_d = (phase_q == c_p_last) ? 3'd0 : phase_q + 3'd1;
                    if (phase_q == 3'd0) begin
                        rcon_d = xtime(rcon_q);
                    end
                    if (idx_q == c_last) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status trails the state by one cycle; a new start hides key_valid at once.
    always_comb begin
        busy_d      = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
        key_valid_d = (state_q == ST_DONE) && !start;
        w_rd_ok     = key_valid_q && !start && (rk_round <= c_nr);
        rk_valid_d  = rk_req && w_rd_ok;
        rk_err_d    = rk_req && !w_rd_ok;
        rk_data_d   = rk_data_q;
        if (rk_valid_d) begin
            rk_data_d = {store_q[{rk_round, 2'b00}], store_q[{rk_round, 2'b01}],
                         store_q[{rk_round, 2'b10}], store_q[{rk_round, 2'b11}]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 6'd0;
            phase_q     <= 3'd0;
            rcon_q      <= 8'h00;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            rk_valid_q  <= 1'b0;
            rk_err_q    <= 1'b0;
            rk_data_q   <= 128'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            rcon_q      <= rcon_d;
            busy_q      <= busy_d;
            key_valid_q <= key_valid_d;
            rk_valid_q  <= rk_valid_d;
            rk_err_q    <= rk_err_d;
            rk_data_q   <= rk_data_d;
        end
    end

    always_ff @(posedge clk) begin
        store_q <= store_d;
    end

    assign busy      = busy_q;
    assign key_valid = key_valid_q;
    assign rk_valid  = rk_valid_q;
    assign rk_err    = rk_err_q;
    assign rk_data   = rk_data_q;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_schedule_ctrl
//  Purpose  : Self-checking bench for key_schedule_ctrl (AES-128/192/256).
//  Revision : 1.0
// ============================================================================
module tb_key_schedule_ctrl;

    typedef logic [31:0] warr_t [60];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KZ   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   start_v = '0;
    logic [2:0]   req_v = '0;
    logic [255:0] key_v [3];
    logic [3:0]   round_v [3];
    logic [2:0]   busy_v, kv_v, rkv_v, rke_v;
    logic [127:0] rkd_v [3];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           s_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_schedule_ctrl #(.NK(4), .NR(10)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key(key_v[0][255:128]),
        .busy(busy_v[0]), .key_valid(kv_v[0]), .rk_req(req_v[0]), .rk_round(round_v[0]),
        .rk_valid(rkv_v[0]), .rk_err(rke_v[0]), .rk_data(rkd_v[0]));

    key_schedule_ctrl #(.NK(6), .NR(12)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key(key_v[1][255:64]),
        .busy(busy_v[1]), .key_valid(kv_v[1]), .rk_req(req_v[1]), .rk_round(round_v[1]),
        .rk_valid(rkv_v[1]), .rk_err(rke_v[1]), .rk_data(rkd_v[1]));

    key_schedule_ctrl #(.NK(8), .NR(14)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key(key_v[2]),
        .busy(busy_v[2]), .key_valid(kv_v[2]), .rk_req(req_v[2]), .rk_round(round_v[2]),
        .rk_valid(rkv_v[2]), .rk_err(rke_v[2]), .rk_data(rkd_v[2]));

    // ---------------- reference arithmetic (GF(2^8) from first principles)
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] ref_subword(input logic [31:0] w);
        return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
    endfunction

    function automatic warr_t ref_expand(input logic [255:0] k, input int nk, input int nr);
        warr_t      w;
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i/nk; j++) rc = gmul(rc, 8'h02);
                t = ref_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = ref_subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return w;
    endfunction

    function automatic logic [127:0] rk_of(input warr_t w, input int r);
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- cycle-level model of the AES-128 instance
    warr_t        m_w;
    int           m_k = 0;
    bit           m_started = 1'b0;
    logic         m_busy = 1'b0, m_kv = 1'b0, m_rkv = 1'b0, m_rke = 1'b0, m_ok = 1'b0;
    logic [127:0] m_rkd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started = 1'b0;
            m_busy = 1'b0; m_kv = 1'b0; m_rkv = 1'b0; m_rke = 1'b0; m_rkd = '0;
        end else begin
            m_ok  = m_kv && !start_v[0] && (round_v[0] <= 4'd10);
            m_rkv = req_v[0] && m_ok;
            m_rke = req_v[0] && !m_ok;
            if (m_rkv) m_rkd = rk_of(m_w, int'(round_v[0]));
            if (start_v[0]) begin
                m_k = 0;
                m_started = 1'b1;
                m_kv = 1'b0;
                m_w = ref_expand(key_v[0], 4, 10);
            end else if (m_started && m_k < 1000) begin
                m_k++;
            end
            if (m_started && m_k >= 1) begin
                m_busy = (m_k < 42);
                m_kv   = (m_k >= 42);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",      busy_v[0], m_busy);
        chk("cyc_key_valid", kv_v[0],   m_kv);
        chk("cyc_rk_valid",  rkv_v[0],  m_rkv);
        chk("cyc_rk_err",    rke_v[0],  m_rke);
        chk("cyc_rk_data",   rkd_v[0],  m_rkd);
    end

    // ---------------- stimulus helpers
    task automatic do_start(input int d, input logic [255:0] k);
        @(posedge clk); #1;
        key_v[d] = k;
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        s_cyc = cyc;
        start_v[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = -1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (kv_v[d]) begin
                lat = cyc - s_cyc;
                break;
            end
        end
    endtask

    task automatic read_rk(input int d, input logic [3:0] r,
                           output logic v, output logic e, output logic [127:0] data);
        @(posedge clk); #1;
        req_v[d] = 1'b1;
        round_v[d] = r;
        @(posedge clk); #1;
        req_v[d] = 1'b0;
        v = rkv_v[d];
        e = rke_v[d];
        data = rkd_v[d];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic v, e;
        logic [127:0] d;
        int lat;
        warr_t w;
        for (int i = 0; i < 3; i++) begin
            key_v[i] = '0;
            round_v[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", busy_v[i], 1'b0);
            chk("rst_key_valid", kv_v[i], 1'b0);
            chk("rst_rk_valid", rkv_v[i], 1'b0);
            chk("rst_rk_err", rke_v[i], 1'b0);
            chk("rst_rk_data", rkd_v[i], 128'h0);
        end
        @(negedge clk) rst_n = 1'b1;

        // model pinned against published vectors
        w = ref_expand(K128, 4, 10);
        chk("model128_r1", rk_of(w, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model128_r10", rk_of(w, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-128 expansion with a read while busy
        do_start(0, K128);
        chk("busy_at_start_edge", busy_v[0], 1'b0);
        read_rk(0, 4'd1, v, e, d);
        chk("busy_read_err", e, 1'b1);
        chk("busy_read_valid", v, 1'b0);
        wait_valid(0, lat);
        chk("lat128", lat, 42);
        chk("busy_after_done", busy_v[0], 1'b0);
        read_rk(0, 4'd1, v, e, d);
        chk("r1_valid", v, 1'b1);
        chk("r1_data", d, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(0, 4'd10, v, e, d);
        chk("r10_data", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(0, 4'd11, v, e, d);
        chk("r11_err", e, 1'b1);
        chk("r11_valid", v, 1'b0);
        chk("r11_data_held", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // back-to-back round-0 reads
        @(posedge clk); #1;
        req_v[0] = 1'b1;
        round_v[0] = 4'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("b2b_valid", rkv_v[0], 1'b1);
            chk("b2b_data", rkd_v[0], K128[255:128]);
        end
        req_v[0] = 1'b0;

        // start and request in the same cycle
        @(posedge clk); #1;
        key_v[0] = K128;
        start_v[0] = 1'b1;
        req_v[0] = 1'b1;
        round_v[0] = 4'd2;
        @(posedge clk); #1;
        s_cyc = cyc;
        start_v[0] = 1'b0;
        req_v[0] = 1'b0;
        chk("start_req_err", rke_v[0], 1'b1);
        chk("start_req_valid", rkv_v[0], 1'b0);
        wait_valid(0, lat);
        chk("lat128_again", lat, 42);

        // restart mid-expansion
        do_start(0, K128);
        repeat (20) @(posedge clk);
        do_start(0, KZ);
        wait_valid(0, lat);
        chk("lat_restart", lat, 42);
        read_rk(0, 4'd10, v, e, d);
        chk("restart_r10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // asynchronous reset mid-expansion
        do_start(0, K128);
        repeat (8) @(posedge clk);
        read_rk(0, 4'd0, v, e, d);
        chk("pre_reset_err", e, 1'b1);
        chk("pre_reset_busy", busy_v[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", busy_v[0], 1'b0);
        chk("async_key_valid", kv_v[0], 1'b0);
        chk("async_rk_valid", rkv_v[0], 1'b0);
        chk("async_rk_err", rke_v[0], 1'b0);
        @(negedge clk) rst_n = 1'b1;
        do_start(0, K128);
        wait_valid(0, lat);
        chk("lat_after_reset", lat, 42);
        read_rk(0, 4'd10, v, e, d);
        chk("post_reset_r10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192
        w = ref_expand(K192, 6, 12);
        chk("model192_w6", w[6], 32'hfe0c91f7);
        chk("model192_r12", rk_of(w, 12), 128'he98ba06f448c773c8ecc720401002202);
        do_start(1, K192);
        wait_valid(1, lat);
        chk("lat192", lat, 48);
        read_rk(1, 4'd1, v, e, d);
        chk("r192_w6", d[63:32], 32'hfe0c91f7);
        chk("r192_r1_model", d, rk_of(w, 1));
        read_rk(1, 4'd12, v, e, d);
        chk("r192_r12", d, 128'he98ba06f448c773c8ecc720401002202);
        read_rk(1, 4'd13, v, e, d);
        chk("r192_r13_err", e, 1'b1);

        // AES-256
        w = ref_expand(K256, 8, 14);
        chk("model256_w12", w[12], 32'ha8b09c1a);
        do_start(2, K256);
        wait_valid(2, lat);
        chk("lat256", lat, 54);
        read_rk(2, 4'd2, v, e, d);
        chk("r256_w8", d[127:96], 32'h9ba35411);
        read_rk(2, 4'd3, v, e, d);
        chk("r256_w12", d[127:96], 32'ha8b09c1a);
        chk("r256_r3_model", d, rk_of(w, 3));
        read_rk(2, 4'd14, v, e, d);
        chk("r256_r14", d, 128'hfe4890d1e6188d0b046df344706c631e);
        read_rk(2, 4'd15, v, e, d);
        chk("r256_r15_err", e, 1'b1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequential AES key-schedule engine and round-key server. On `start` it latches a cipher key and generates one expanded word per cycle through a single shared 4-byte SubWord unit. It stores all 4*(NR+1) words and then serves 128-bit round keys to the encrypt/decrypt round controllers through a request/valid port. It replaces the fully unrolled combinational expansion where area or timing matter.

Parameters:
NK, 4, key length in 32-bit words (4/6/8 for AES-128/192/256)
NR, 10, number of rounds (10/12/14; must pair with NK)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latch key and begin expansion
key  in  NK*32  cipher key; word 0 = key[NK*32-1 -: 32]
busy  out  1  high while expansion is in progress
key_valid  out  1  high once all words are stored, until the next start or reset
rk_req  in  1  round-key read request
rk_round  in  4  round index 0..NR
rk_valid  out  1  one-cycle pulse carrying rk_data
rk_err  out  1  one-cycle pulse: request rejected
rk_data  out  128  round key; word 4r in [127:96], word 4r+3 in [31:0]

Behaviour:
- Reset (asynchronous): state IDLE; busy, key_valid, rk_valid and rk_err = 0; rk_data = 0. Word store contents are don't-care.
- FSM states: IDLE, LOAD, EXPAND, DONE.
- IDLE or DONE, with start=1: go to LOAD. key_valid drops in the next cycle.
- LOAD (1 cycle):
  - write key words 0..NK-1 into the store;
  - i = NK; phase counter p = 0 (tracks i mod NK, no divider);
  - rcon = 8'h01; busy = 1.
- EXPAND (1 word per cycle):
  - temp = w[i-1].
  - If p == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}; rcon advances by xtime (01,02,...,80,1b,36).
  - Else if NK > 6 and p == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - i++; p wraps at NK-1 back to 0.
  - After writing word 4*(NR+1)-1, go to DONE.
- EXPAND latency is 4*(NR+1)-NK cycles: 40 / 46 / 52 for NK = 4 / 6 / 8.
- Timing from the edge that samples start: busy rises 1 cycle later. key_valid rises and busy falls 2 + (4*(NR+1)-NK) cycles later: 42 / 48 / 54.
- DONE: key_valid = 1, busy = 0.
- start while busy (LOAD/EXPAND): abort and restart from LOAD with the new key. No partial key_valid is ever shown.
- Read port:
  - rk_req is sampled each cycle; exactly one of rk_valid / rk_err pulses on the next cycle.
  - rk_valid when key_valid = 1 and rk_round <= NR, with rk_data = words 4r..4r+3.
  - rk_err otherwise (not valid, busy, or out of range); rk_data holds its previous value.
  - start and rk_req in the same cycle: the request is evaluated against the post-start state, so it yields rk_err.
  - Back-to-back requests give back-to-back responses (full throughput).
- rcon is at most 8 bits. Every index in range 0..59 fits in 6 bits. The store is a 4*(NR+1) x 32 register array.

Decomposition:
- Package aes_pkg:
  - word type (32 bits);
  - S-box function/table;
  - xtime function;
  - FSM state enum;
  - constant function NWORDS = 4*(NR+1).
- One sub-module, aes_subword: purely combinational, 4 parallel S-box lookups on a 32-bit word. It is shared by both SubWord cases and reused later by the cipher datapath.

Test Plan:
- AES-128: start with key 2b7e151628aed2a6abf7158809cf4f3c, then poll until key_valid.
  - key_valid rises exactly 42 cycles after start is sampled.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 (NK=6, NR=12): key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - w[6] = fe0c91f7.
  - Round 12 = e98ba06f448c773c8ecc720401002202.
  - Latency 48 cycles.
- AES-256 (NK=8, NR=14): key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - w[8] = 9ba35411; w[12] = a8b09c1a (checks the p == 4 SubWord case).
  - Round 14 = fe4890d1e6188d0b046df344706c631e.
  - Latency 54 cycles.
- Read port checks:
  - rk_req while busy -> rk_err pulse, no rk_valid.
  - rk_round = 11 on AES-128 -> rk_err.
  - rk_round = 0 on consecutive cycles -> consecutive rk_valid pulses carrying the original key.
- Restart: issue a second start at cycle 20 of an AES-128 expansion with key 000102030405060708090a0b0c0d0e0f.
  - key_valid stays 0 until 42 cycles after the second start.
  - Round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Reset mid-EXPAND: assert rst_n = 0 asynchronously.
  - busy, key_valid, rk_valid and rk_err go to 0 immediately, with no clock edge.
  - A subsequent start produces correct keys.
